// File: rtl/xbee_cmd_decoder_if.sv
// Byte-stream and motor-command bundle between the UART receiver, the
// command decoder and the motor-control mux.
interface xbee_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] motctl;
  logic       cmd_valid;
  logic       link_up;
  logic [7:0] frame_err_cnt;

  // Byte source side: drives received bytes and observes the decoder results.
  modport master (
    output rx_data,
    output rx_valid,
    input  motctl,
    input  cmd_valid,
    input  link_up,
    input  frame_err_cnt
  );

  // Decoder side: consumes received bytes and produces the motor command.
  modport slave (
    input  rx_data,
    input  rx_valid,
    output motctl,
    output cmd_valid,
    output link_up,
    output frame_err_cnt
  );
endinterface

// File: rtl/xbee_cmd_decoder.sv
// Xbee motor-command decoder: frames SYNC/CMD/CHK byte triplets, validates
// them, remaps the command bits to the motor-control layout and forces a
// motor stop when accepted frames stop arriving.
module xbee_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES  = 25_000_000,
  parameter int unsigned BYTE_GAP_CYCLES = 200_000,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
  input logic               clk,
  input logic               reset_n,
  xbee_cmd_decoder_if.slave bus
);

  localparam int unsigned WD_W  = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;
  localparam int unsigned GAP_W = (BYTE_GAP_CYCLES > 1) ? $clog2(BYTE_GAP_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_SYNC = 2'd1,
    ST_GOT_CMD  = 2'd2
  } state_e;

  // A frame is good when the check byte is the bitwise complement of the
  // command and the reserved low nibble of the command is clear.
  function automatic logic frame_ok(input logic [7:0] cmd, input logic [7:0] chk);
    return (chk == ~cmd) && (cmd[3:0] == 4'b0000);
  endfunction

  // Command bits [7:4] map onto the left/right forward/reverse motor pins.
  function automatic logic [7:0] remap_cmd(input logic [7:0] cmd);
    return {2'b00, cmd[4], cmd[5], 2'b00, cmd[6], cmd[7]};
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [7:0]       motctl_q, motctl_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             link_up_q, link_up_d;
  logic [7:0]       err_q, err_d;

  logic             accept_s;
  logic             frame_err_s;
  logic             wd_expire_s;

  // Frame parser: next state, command capture, accept and error events.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    accept_s    = 1'b0;
    frame_err_s = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_d = ST_GOT_SYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GOT_SYNC: begin
          cmd_d   = bus.rx_data;
          state_d = ST_GOT_CMD;
        end
        ST_GOT_CMD: begin
          if (frame_ok(cmd_q, bus.rx_data)) begin
            accept_s = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_err_s = 1'b1;
            // A rejected check byte may itself be the start of the next frame.
            if (bus.rx_data == SYNC_BYTE) begin
              state_d = ST_GOT_SYNC;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if ((state_q != ST_IDLE) && (gap_q == GAP_LAST)) begin
      // Sender stalled inside a frame: abandon it and count it as bad.
      state_d     = ST_IDLE;
      frame_err_s = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // Inter-byte gap timer: only runs while a frame is partially received.
  always_comb begin
    gap_d = gap_q;
    if (bus.rx_valid) begin
      gap_d = '0;
    end else if (state_q == ST_IDLE) begin
      gap_d = '0;
    end else if (gap_q == GAP_LAST) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  // Link watchdog and registered output values; an accept beats a timeout.
  always_comb begin
    wd_d        = wd_q;
    wd_expire_s = 1'b0;
    motctl_d    = motctl_q;
    link_up_d   = link_up_q;
    cmd_valid_d = accept_s;
    err_d       = err_q;

    if (accept_s) begin
      wd_d = '0;
    end else if (wd_q == WD_LAST) begin
      wd_d        = wd_q;
      wd_expire_s = 1'b1;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end

    if (accept_s) begin
      motctl_d  = remap_cmd(cmd_q);
      link_up_d = 1'b1;
    end else if (wd_expire_s) begin
      motctl_d  = 8'h00;
      link_up_d = 1'b0;
    end else begin
      motctl_d  = motctl_q;
      link_up_d = link_up_q;
    end

    if (frame_err_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'h01;
    end else begin
      err_d = err_q;
    end
  end

  // Parser state, captured command and both counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= 8'h00;
      gap_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
    end
  end

  // Registered outputs towards the motor-control mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      motctl_q    <= 8'h00;
      cmd_valid_q <= 1'b0;
      link_up_q   <= 1'b0;
      err_q       <= 8'h00;
    end else begin
      motctl_q    <= motctl_d;
      cmd_valid_q <= cmd_valid_d;
      link_up_q   <= link_up_d;
      err_q       <= err_d;
    end
  end

  assign bus.motctl        = motctl_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.link_up       = link_up_q;
  assign bus.frame_err_cnt = err_q;

endmodule

// File: doc/xbee_cmd_decoder.md
# xbee_cmd_decoder

Frames and validates motor-command bytes arriving from the Xbee UART receiver and presents a registered, fail-safe motor-control byte to the Android/PicoBlaze motor-command mux. It sits directly downstream of the UART byte receiver and upstream of the motor-control mux. The block parses a 3-byte frame, checks its integrity and remaps command bits to the motor-control layout. A link watchdog forces the motors to stop when valid commands stop arriving.

## Interface
- TIMEOUT_CYCLES, 25_000_000: cycles without an accepted frame before the link is declared down (250 ms at 100 MHz).
- BYTE_GAP_CYCLES, 200_000: maximum cycles allowed between bytes inside one frame (2 ms).
- SYNC_BYTE, 8'hA5: frame start marker.

- clk  in  1  100 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle. May assert on consecutive cycles.
- motctl  out  8  motor-control byte {2'b00, L_fwd, L_rev, 2'b00, R_fwd, R_rev}.
- cmd_valid  out  1  one-cycle pulse when motctl is updated from an accepted frame.
- link_up  out  1  high while accepted frames arrive within TIMEOUT_CYCLES.
- frame_err_cnt  out  8  saturating count of rejected or abandoned frames.

## Operation
- Frame format: SYNC_BYTE, CMD, CHK.
  - The frame is valid when CHK == ~CMD and CMD[3:0] == 4'b0000.
- FSM states are IDLE, GOT_SYNC and GOT_CMD. Transitions only on rx_valid, except the gap timeout.
  - IDLE: byte == SYNC_BYTE -> GOT_SYNC. Any other byte is ignored and is not an error.
  - GOT_SYNC: capture the byte into cmd_reg -> GOT_CMD. SYNC_BYTE is legal as CMD, and its frame still fails the CMD[3:0] check.
  - GOT_CMD, valid CHK: accept the frame -> IDLE.
  - GOT_CMD, invalid CHK or nonzero CMD[3:0]: increment frame_err_cnt. Go to GOT_SYNC if the byte == SYNC_BYTE (resync), else IDLE.
- Gap timer:
  - Clears on every rx_valid and counts while in GOT_SYNC or GOT_CMD.
  - On reaching BYTE_GAP_CYCLES-1: -> IDLE and increment frame_err_cnt.
  - If rx_valid arrives in the same cycle, the byte wins and the gap timer is cleared.
- Accept:
  - motctl <= {2'b00, CMD[4], CMD[5], 2'b00, CMD[6], CMD[7]}.
  - cmd_valid pulses, link_up <= 1 and the watchdog counter clears.
- Watchdog:
  - The counter increments every cycle and saturates at TIMEOUT_CYCLES-1.
  - On reaching TIMEOUT_CYCLES-1 with no accept in that cycle: link_up <= 0 and motctl <= 8'h00 (stop).
  - If an accept and the timeout coincide, the accept wins.
- frame_err_cnt saturates at 8'hFF and clears only on reset.
- Counter widths use $clog2 of the respective parameter.

## Timing
- Reset (asynchronous, on reset_n low): FSM = IDLE; motctl = 8'h00; cmd_valid = 0; link_up = 0; frame_err_cnt = 0; both counters = 0.
- Reset asserted mid-frame discards the partial frame without counting an error.
- All outputs are registered.
  - Latency: the rx_valid cycle of the CHK byte -> motctl, cmd_valid and link_up update at the next rising edge.
  - cmd_valid is high for exactly one cycle per accepted frame.
- Back-to-back frames with rx_valid every cycle are accepted with no bubbles: minimum 3 cycles per frame.
- A repeated identical command still pulses cmd_valid and re-arms the watchdog.
- Link drop occurs exactly TIMEOUT_CYCLES cycles after the last accept edge.

## Test plan
- Reset, then bytes A5, 10, EF -> one cycle after EF: motctl = 8'h20, cmd_valid pulses once, link_up = 1, frame_err_cnt = 0.
- A5, C0, 3F -> motctl = 8'h03. Then A5, 80, 00 (bad CHK) -> motctl unchanged at 8'h03, frame_err_cnt = 1, no cmd_valid.
- Resync: A5, 10, A5, 20, DF -> first frame rejected (err = 1), resync on the third byte, motctl = 8'h10.
- Gap: A5, 10, then idle for BYTE_GAP_CYCLES -> FSM returns to IDLE, err increments. A late EF is ignored and motctl is unchanged.
- Watchdog, run with TIMEOUT_CYCLES = 100:
  - Accept a frame, then no traffic -> exactly 100 cycles later link_up = 0 and motctl = 8'h00.
  - A frame whose CHK lands on the timeout cycle keeps link_up = 1.
- Saturation plus async reset: 300 bad frames -> frame_err_cnt = 8'hFF. Pulse reset_n low mid-frame without a clk edge -> all outputs return to their reset values immediately.
